// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer
// Drives a 1-bit ALU slice bit-serially. It takes a WIDTH-bit request, presents
// operand bits LSB-first, chains the slice carry from one bit to the next, and
// returns the assembled result and final carry on a valid/ready port.
// Optional feature macro: SERIAL_ALU_FLAGS_EN adds the rsp_zero / rsp_ovf flags.
module serial_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_op1,
  input  logic [WIDTH-1:0] req_op2,
  input  logic             req_cin,
  input  logic [2:0]       req_opsel,
  input  logic             req_mode,
  output logic             slice_op1,
  output logic             slice_op2,
  output logic             slice_cin,
  output logic [2:0]       slice_opsel,
  output logic             slice_mode,
  input  logic             slice_result,
  input  logic             slice_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             carry_q, carry_d;
  logic [2:0]       opsel_q, opsel_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_cout_q, rsp_cout_d;
`ifdef SERIAL_ALU_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  // Next-state and datapath: load on accept, shift one bit per RUN cycle, hold in DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    carry_d      = carry_q;
    opsel_d      = opsel_q;
    mode_d       = mode_q;
    res_sh_d     = res_sh_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
    zero_d       = zero_q;
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          op1_d       = req_op1;
          op2_d       = req_op2;
          carry_d     = req_cin;
          opsel_d     = req_opsel;
          mode_d      = req_mode;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          state_d     = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Result enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        res_sh_d = {slice_result, res_sh_q[WIDTH-1:1]};
        op1_d    = {1'b0, op1_q[WIDTH-1:1]};
        op2_d    = {1'b0, op2_q[WIDTH-1:1]};
        carry_d  = slice_cout;
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish result; the counter never advances past WIDTH-1.
          rsp_result_d = res_sh_d;
          rsp_cout_d   = slice_cout;
          rsp_valid_d  = 1'b1;
          cnt_d        = '0;
          state_d      = DONE;
`ifdef SERIAL_ALU_FLAGS_EN
          zero_d = (res_sh_d == '0);
          // carry_q is the carry into the MSB during the last bit.
          ovf_d  = mode_q ? 1'b0 : (carry_q ^ slice_cout);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      carry_q      <= 1'b0;
      opsel_q      <= 3'b000;
      mode_q       <= 1'b0;
      res_sh_q     <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      carry_q      <= carry_d;
      opsel_q      <= opsel_d;
      mode_q       <= mode_d;
      res_sh_q     <= res_sh_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
`ifdef SERIAL_ALU_FLAGS_EN
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  // Outputs come straight from flops; operand shift regs drain to zero after each op.
  assign req_ready   = req_ready_q;
  assign slice_op1   = op1_q[0];
  assign slice_op2   = op2_q[0];
  assign slice_cin   = carry_q;
  assign slice_opsel = opsel_q;
  assign slice_mode  = mode_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_cout    = rsp_cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
  assign rsp_zero    = zero_q;
  assign rsp_ovf     = ovf_q;
`endif

endmodule
